// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller in front of the multiply/divide unit: registers MD
// operands into the MDU, interlocks EX while the MDU is occupied, muxes HI/LO.
module md_issue_ctrl #(
   parameter int unsigned TIMEOUT   = 16,
   parameter bit          DIV0_SKIP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic        mdu_start,
   output logic [5:0]  mdu_op,
   output logic [31:0] mdu_d1,
   output logic [31:0] mdu_d2,
   output logic        stall,
   output logic [31:0] mf_data,
   output logic        div0,
   output logic        err
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned CNT_W   = 8;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MFLO  = 3'd7;

   localparam logic [FUNCT_W-1:0] FN_NONE = 6'h00;
   localparam logic [FUNCT_W-1:0] FN_MTHI = 6'h11;
   localparam logic [FUNCT_W-1:0] FN_MTLO = 6'h13;
   localparam logic [FUNCT_W-1:0] FN_MULT = 6'h18;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT
   } state_e;

   state_e              state_q, state_d;
   logic                start_q, start_d;
   logic [FUNCT_W-1:0]  funct_q, funct_d;
   logic [DATA_W-1:0]   d1_q, d1_d;
   logic [DATA_W-1:0]   d2_q, d2_d;
   logic                is_md_q, is_md_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                div0_q, div0_d;

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         funct_q <= FN_NONE;
         d1_q    <= '0;
         d2_q    <= '0;
         is_md_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         funct_q <= funct_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         is_md_q <= is_md_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         div0_q  <= div0_d;
      end
   end

   // Next-state and issue logic
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      funct_d = funct_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      is_md_d = is_md_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      div0_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     if (DIV0_SKIP && op[1] && (rt_val == '0)) begin
                        div0_d = 1'b1;
                     end else begin
                        d1_d    = rs_val;
                        d2_d    = rt_val;
                        funct_d = FN_MULT | FUNCT_W'(op[1:0]);
                        start_d = 1'b1;
                        is_md_d = 1'b1;
                        state_d = S_LAUNCH;
                     end
                  end
                  OP_MTHI, OP_MTLO: begin
                     d1_d    = rs_val;
                     funct_d = (op == OP_MTHI) ? FN_MTHI : FN_MTLO;
                     start_d = 1'b0;
                     is_md_d = 1'b0;
                     state_d = S_LAUNCH;
                  end
                  default: ;
               endcase
            end
         end
         S_LAUNCH: begin
            // Clear funct so the MDU does not keep re-applying MTHI/MTLO
            start_d = 1'b0;
            funct_d = FN_NONE;
            cnt_d   = '0;
            state_d = is_md_q ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // BUSY is not yet valid on the first WAIT edge; completion beats timeout
            if (!mdu_busy && (cnt_q != '0)) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stall     = op_valid && (state_q != S_IDLE);
   assign mf_data   = (op == OP_MFLO) ? mdu_lo : mdu_hi;

   assign mdu_start = start_q;
   assign mdu_op    = funct_q;
   assign mdu_d1    = d1_q;
   assign mdu_d2    = d2_q;
   assign div0      = div0_q;
   assign err       = err_q;

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue and hazard controller directly upstream of the multiply/divide unit (MDU), sitting at the EX stage of the pipelined MIPS core.
- Accepts MD-class instructions from EX: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Registers the operands and drives the MDU's start/op/D1/D2 inputs.
- Tracks MDU occupancy, stalls EX on MD hazards, and returns HI/LO for MFHI/MFLO.

Parameters:
- TIMEOUT, 16, max cycles in WAIT before err is raised; range 2..255.
- DIV0_SKIP, 1, 1 = a DIV/DIVU with rt_val==0 is not launched (HI/LO unchanged); 0 = launched normally.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  EX holds an MD-class instruction
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- mdu_busy  in  1  MDU BUSY output
- mdu_hi  in  32  MDU HI output
- mdu_lo  in  32  MDU LO output
- mdu_start  out  1  MDU start, registered
- mdu_op  out  6  MDU funct code, registered
- mdu_d1  out  32  MDU D1, registered
- mdu_d2  out  32  MDU D2, registered
- stall  out  1  hold EX/ID/IF this cycle, combinational
- mf_data  out  32  HI (op 6) or LO (op 7), combinational
- div0  out  1  one-cycle pulse: divide by zero suppressed
- err  out  1  sticky: WAIT exceeded TIMEOUT

Behaviour:
- Reset (reset=1 at posedge): state=IDLE; mdu_start=0, mdu_op=0, mdu_d1=0, mdu_d2=0, div0=0, err=0, counter=0. Reset mid-operation abandons the op; the MDU is reset by the same signal.
- States:
  - IDLE: no MD work in flight.
  - LAUNCH: registered op presented to the MDU for exactly one cycle.
  - WAIT: MDU computing.
- Capture (state IDLE, op_valid=1, stall=0, at posedge):
  - MULT/MULTU/DIV/DIVU: mdu_d1<=rs_val, mdu_d2<=rt_val, mdu_op<=0x18/0x19/0x1A/0x1B, mdu_start<=1, ->LAUNCH.
  - MTHI/MTLO: mdu_d1<=rs_val, mdu_op<=0x11/0x13, mdu_start<=0, ->LAUNCH.
  - MFHI/MFLO: no register change, stay IDLE.
  - The instruction leaves EX in its capture cycle (stall=0).
- Div-by-zero (DIV/DIVU, rt_val==0, DIV0_SKIP=1): no launch, stay IDLE, div0=1 for the next cycle only.
- LAUNCH (one cycle, at posedge): mdu_start<=0, mdu_op<=0. mdu_op must return to 0 so the MDU does not re-apply MTHI/MTLO on later cycles.
  - Previous op was mult/div: ->WAIT, counter<=0.
  - Previous op was MTHI/MTLO: ->IDLE.
- WAIT:
  - Each cycle: counter++ (saturating).
  - mdu_busy==0 sampled at posedge with counter>=1: ->IDLE. The first WAIT cycle is always spent, because BUSY rises one edge after start.
  - counter==TIMEOUT: err<=1 (sticky until reset), ->IDLE.
- stall = op_valid & (state != IDLE). This covers MF after MT/mult/div, back-to-back mult/div, and MT during a busy MDU. Non-MD instructions never stall here.
- mf_data = (op==7) ? mdu_lo : mdu_hi. Valid only when op_valid & stall==0 & op in {6,7}.
- mdu_d2 is unchanged on MTHI/MTLO.
- Latency: MULT issued at edge E0 -> mdu_start=1 during E0..E1 -> WAIT from E1. A dependent MFLO is held until the cycle after mdu_busy falls.
- Simultaneous events: reset has priority over all. In IDLE, capture and div0 are mutually exclusive per op.

Test Plan:
- Reset, then MULT rs=7 rt=-3 -> mdu_start=1 for one cycle with mdu_op=0x18, mdu_d1=7, mdu_d2=0xFFFFFFFD; a following MFLO stalls until BUSY drops, then mf_data=0xFFFFFFEB, and MFHI returns 0xFFFFFFFF.
- MTHI rs=0x12345678 then MFHI on the next cycle -> exactly one stall cycle (LAUNCH); mf_data=0x12345678; mdu_op=0 afterwards.
- DIVU rs=100 rt=0 with DIV0_SKIP=1 -> no mdu_start, div0 pulses once, HI/LO unchanged, no stall on the next MD op.
- DIV rs=-17 rt=5 followed immediately by MULTU -> MULTU stalls through LAUNCH+WAIT; after completion LO=0xFFFFFFFD, HI=0xFFFFFFFE; MULTU then launches.
- Hold mdu_busy=1 forever after a MULT with TIMEOUT=16 -> err=1 after 16 WAIT cycles, state returns to IDLE, err stays 1 until reset.
- Assert reset during WAIT -> all outputs 0, state IDLE, stall=0 on the next cycle even with op_valid=1 and op=MFHI.
